// File: rtl/sc_exec_mem_stage_if.sv
// rtl/sc_exec_mem_stage_if.sv - datapath bundle between register fetch, exec/mem stage and writeback
interface sc_exec_mem_stage_if #(parameter int DBITS = 32);
  logic [31:0]      inst_word;
  logic [DBITS-1:0] rd_val;
  logic [DBITS-1:0] rs1_val;
  logic [DBITS-1:0] rs2_val;
  logic             use_zero;
  logic             use_imm;
  logic             is_mvhi;
  logic             is_bcond;
  logic [3:0]       op_alu;
  logic [3:0]       op_cond;
  logic             wr_en_mem;
  logic [3:0]       op1;
  logic [3:0]       op2;
  logic [3:0]       rd;
  logic [3:0]       rs1;
  logic [3:0]       rs2;
  logic [15:0]      imm16;
  logic [31:0]      imm32;
  logic [DBITS-1:0] alu_out;
  logic             cond_out;
  logic [DBITS-1:0] mem_out;

  modport master (
    output inst_word, rd_val, rs1_val, rs2_val, use_zero, use_imm, is_mvhi, is_bcond,
           op_alu, op_cond, wr_en_mem,
    input  op1, op2, rd, rs1, rs2, imm16, imm32, alu_out, cond_out, mem_out
  );

  modport slave (
    input  inst_word, rd_val, rs1_val, rs2_val, use_zero, use_imm, is_mvhi, is_bcond,
           op_alu, op_cond, wr_en_mem,
    output op1, op2, rd, rs1, rs2, imm16, imm32, alu_out, cond_out, mem_out
  );
endinterface

// File: rtl/sc_exec_mem_stage.sv
// rtl/sc_exec_mem_stage.sv - single-cycle decode/ALU/condition back end with data RAM and board I/O
module sc_exec_mem_stage #(
  parameter int          DBITS        = 32,
  parameter int          DMEMWORDS    = 2048,
  parameter int          DMEMADDRBITS = 13,
  parameter logic [31:0] ADDR_HEX     = 32'hF0000000,
  parameter logic [31:0] ADDR_LEDR    = 32'hF0000004,
  parameter logic [31:0] ADDR_LEDG    = 32'hF0000008,
  parameter logic [31:0] ADDR_KEY     = 32'hF0000010,
  parameter logic [31:0] ADDR_SW      = 32'hF0000014
) (
  input  logic                  clk,
  input  logic                  reset,
  sc_exec_mem_stage_if.slave    bus,
  input  logic [9:0]            SW,
  input  logic [3:0]            KEY,
  output logic [9:0]            LEDR,
  output logic [7:0]            LEDG,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX2,
  output logic [6:0]            HEX3
);

  logic [DBITS-1:0]        opA, opB, aluRes, aluOut;
  logic signed [DBITS-1:0] condX, condY;
  logic                    condRes, isCmp, isIo;
  logic [15:0]             hexReg;
  logic [DMEMADDRBITS-3:0] ramIdx;
  logic [DBITS-1:0]        ram [0:DMEMWORDS-1];

  assign bus.op1   = bus.inst_word[31:28];
  assign bus.op2   = bus.inst_word[27:24];
  assign bus.rd    = bus.inst_word[23:20];
  assign bus.rs1   = bus.inst_word[19:16];
  assign bus.rs2   = bus.inst_word[15:12];
  assign bus.imm16 = bus.inst_word[15:0];
  assign bus.imm32 = {{16{bus.inst_word[15]}}, bus.inst_word[15:0]};

  assign opA = bus.use_zero ? '0 : bus.rs1_val;
  assign opB = bus.use_imm ? bus.imm32 : bus.rs2_val;

  always_comb begin
    aluRes = '0;
    case (bus.op_alu)
      4'h0: aluRes = opA + opB;
      4'h1: aluRes = opA - opB;
      4'h4: aluRes = opA & opB;
      4'h5: aluRes = opA | opB;
      4'h6: aluRes = opA ^ opB;
      4'hC: aluRes = ~(opA & opB);
      4'hD: aluRes = ~(opA | opB);
      4'hE: aluRes = ~(opA ^ opB);
      default: aluRes = '0;
    endcase
  end

  // Branch form compares two registers directly; other forms compare the ALU operands.
  assign condX = bus.is_bcond ? $signed(bus.rd_val)  : $signed(opA);
  assign condY = bus.is_bcond ? $signed(bus.rs1_val) : $signed(opB);

  always_comb begin
    condRes = 1'b0;
    case (bus.op_cond)
      4'h1: condRes = (condX == condY);
      4'h2: condRes = (condX <  condY);
      4'h3: condRes = (condX <= condY);
      4'h5: condRes = (condX == 0);
      4'h6: condRes = (condX <  0);
      4'h7: condRes = (condX <= 0);
      4'h8: condRes = 1'b1;
      4'h9: condRes = (condX != condY);
      4'hA: condRes = (condX >= condY);
      4'hB: condRes = (condX >  condY);
      4'hD: condRes = (condX != 0);
      4'hE: condRes = (condX >= 0);
      4'hF: condRes = (condX >  0);
      default: condRes = 1'b0;
    endcase
  end

  assign isCmp = (bus.op1 == 4'b0010) || (bus.op1 == 4'b1010);

  always_comb begin
    aluOut = aluRes;
    if (bus.is_mvhi)
      aluOut = {bus.imm16, 16'h0000};
    else if (isCmp)
      aluOut = {{(DBITS-1){1'b0}}, condRes};
  end

  assign bus.alu_out  = aluOut;
  assign bus.cond_out = condRes;

  assign isIo = (aluOut == ADDR_HEX) || (aluOut == ADDR_LEDR) || (aluOut == ADDR_LEDG) ||
                (aluOut == ADDR_KEY) || (aluOut == ADDR_SW);
  assign ramIdx = aluOut[DMEMADDRBITS-1:2];

  // RAM shares the async reset only to block a store while reset is low; contents are kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (bus.wr_en_mem && !isIo) begin
      ram[ramIdx] <= bus.rs2_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hexReg <= '0;
      LEDR   <= '0;
      LEDG   <= '0;
    end else if (bus.wr_en_mem) begin
      if (aluOut == ADDR_HEX)  hexReg <= bus.rs2_val[15:0];
      if (aluOut == ADDR_LEDR) LEDR   <= bus.rs2_val[9:0];
      if (aluOut == ADDR_LEDG) LEDG   <= bus.rs2_val[7:0];
    end
  end

  always_comb begin
    bus.mem_out = ram[ramIdx];
    if (aluOut == ADDR_KEY)       bus.mem_out = {{(DBITS-4){1'b0}}, KEY};
    else if (aluOut == ADDR_SW)   bus.mem_out = {{(DBITS-10){1'b0}}, SW};
    else if (aluOut == ADDR_HEX)  bus.mem_out = {{(DBITS-16){1'b0}}, hexReg};
    else if (aluOut == ADDR_LEDR) bus.mem_out = {{(DBITS-10){1'b0}}, LEDR};
    else if (aluOut == ADDR_LEDG) bus.mem_out = {{(DBITS-8){1'b0}}, LEDG};
  end

  function automatic logic [6:0] segOf(input logic [3:0] nib);
    case (nib)
      4'h0: segOf = 7'b1000000;
      4'h1: segOf = 7'b1111001;
      4'h2: segOf = 7'b0100100;
      4'h3: segOf = 7'b0110000;
      4'h4: segOf = 7'b0011001;
      4'h5: segOf = 7'b0010010;
      4'h6: segOf = 7'b0000010;
      4'h7: segOf = 7'b1111000;
      4'h8: segOf = 7'b0000000;
      4'h9: segOf = 7'b0010000;
      4'hA: segOf = 7'b0001000;
      4'hB: segOf = 7'b0000011;
      4'hC: segOf = 7'b1000110;
      4'hD: segOf = 7'b0100001;
      4'hE: segOf = 7'b0000110;
      default: segOf = 7'b0001110;
    endcase
  endfunction

  assign HEX0 = segOf(hexReg[3:0]);
  assign HEX1 = segOf(hexReg[7:4]);
  assign HEX2 = segOf(hexReg[11:8]);
  assign HEX3 = segOf(hexReg[15:12]);

endmodule

// File: tb/tb_sc_exec_mem_stage.sv
// tb/tb_sc_exec_mem_stage.sv - directed self-checking bench for sc_exec_mem_stage
module tb_sc_exec_mem_stage;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  int checks = 0;
  int errors = 0;

  sc_exec_mem_stage_if bus ();

  sc_exec_mem_stage dut (
    .clk(clk), .reset(reset), .bus(bus), .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.inst_word = '0; bus.rd_val = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.use_zero = 0; bus.use_imm = 0; bus.is_mvhi = 0; bus.is_bcond = 0;
    bus.op_alu = 4'h0; bus.op_cond = 4'h0; bus.wr_en_mem = 0;
  endtask

  // Address formed as rs1_val + imm16 (ADDI form).
  task automatic addr(input logic [31:0] base, input logic [15:0] off);
    idle();
    bus.inst_word = {16'h0, off}; bus.rs1_val = base; bus.use_imm = 1;
  endtask

  task automatic store(input logic [31:0] base, input logic [15:0] off, input logic [31:0] data);
    addr(base, off);
    bus.rs2_val = data; bus.wr_en_mem = 1;
    @(posedge clk); #1;
    bus.wr_en_mem = 0;
  endtask

  initial begin
    reset = 0; SW = 10'h3FF; KEY = 4'hA;
    idle();
    #1;
    check("rst_ledr", {22'h0, LEDR}, 32'h0);
    check("rst_ledg", {24'h0, LEDG}, 32'h0);
    check("rst_hex0", {25'h0, HEX0}, 32'h40);
    check("rst_hex3", {25'h0, HEX3}, 32'h40);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    bus.inst_word = 32'h80860BEF; bus.use_imm = 1; #1;
    check("dec_op1", {28'h0, bus.op1}, 32'h8);
    check("dec_rd", {28'h0, bus.rd}, 32'h8);
    check("dec_rs1", {28'h0, bus.rs1}, 32'h6);
    check("dec_imm32", bus.imm32, 32'h00000BEF);
    check("addi_bef", bus.alu_out, 32'h00000BEF);

    idle(); bus.rs1_val = 32'hFFFFFFFF; bus.rs2_val = 32'h2; #1;
    check("add_wrap", bus.alu_out, 32'h00000001);
    idle(); bus.op_alu = 4'h1; bus.rs2_val = 32'h1; #1;
    check("sub_wrap", bus.alu_out, 32'hFFFFFFFF);
    addr(32'h5, 16'hFFFF); #1;
    check("addi_imm32", bus.imm32, 32'hFFFFFFFF);
    check("addi_neg", bus.alu_out, 32'h00000004);
    bus.use_zero = 1; bus.rs1_val = 32'h1234; bus.inst_word = 32'h5; #1;
    check("use_zero", bus.alu_out, 32'h00000005);

    idle(); bus.rs1_val = 32'hF0F0F0F0; bus.rs2_val = 32'hFF00FF00;
    bus.op_alu = 4'h4; #1; check("and", bus.alu_out, 32'hF000F000);
    bus.op_alu = 4'h6; #1; check("xor", bus.alu_out, 32'h0FF00FF0);
    bus.op_alu = 4'hD; #1; check("nor", bus.alu_out, 32'h000F000F);
    bus.op_alu = 4'hC; #1; check("nand", bus.alu_out, 32'h0FFF0FFF);
    bus.op_alu = 4'h2; #1; check("undef_op", bus.alu_out, 32'h0);

    idle(); bus.is_mvhi = 1; bus.inst_word = 32'h2000F000; bus.op_cond = 4'h8; #1;
    check("mvhi", bus.alu_out, 32'hF0000000);

    idle(); bus.is_bcond = 1; bus.rd_val = 32'h278; bus.rs1_val = 32'h278;
    bus.op_cond = 4'h1; #1; check("beq_t", {31'h0, bus.cond_out}, 32'h1);
    bus.op_cond = 4'h9; #1; check("bne_f", {31'h0, bus.cond_out}, 32'h0);
    bus.rd_val = 32'hFFFFFFFF; bus.rs1_val = 32'h1;
    bus.op_cond = 4'h2; #1; check("blt_signed", {31'h0, bus.cond_out}, 32'h1);
    bus.op_cond = 4'hB; #1; check("bgt_signed", {31'h0, bus.cond_out}, 32'h0);
    bus.op_cond = 4'h6; #1; check("bltz", {31'h0, bus.cond_out}, 32'h1);
    bus.op_cond = 4'h4; #1; check("cond4_zero", {31'h0, bus.cond_out}, 32'h0);

    idle(); bus.inst_word = 32'h20000000; bus.op_alu = 4'h1; bus.op_cond = 4'h2;
    bus.rs1_val = 32'h3; bus.rs2_val = 32'h7; #1;
    check("cmp_lt", bus.alu_out, 32'h00000001);

    store(32'h0, 16'h0008, 32'hCAFEF00D);
    store(32'hF0000000, 16'h0008, 32'h1);
    check("ledg_store", {24'h0, LEDG}, 32'h01);
    addr(32'h0, 16'h0008); #1;
    check("ram2_kept", bus.mem_out, 32'hCAFEF00D);

    store(32'h0, 16'h0100, 32'hDEADBEEF);
    addr(32'h0, 16'h0100); #1;
    check("load_100", bus.mem_out, 32'hDEADBEEF);
    addr(32'h0, 16'h2100); #1;
    check("load_alias", bus.mem_out, 32'hDEADBEEF);
    addr(32'hF0000014, 16'h0); #1;
    check("load_sw", bus.mem_out, 32'h000003FF);
    addr(32'hF0000010, 16'h0); #1;
    check("load_key", bus.mem_out, 32'h0000000A);

    store(32'h0, 16'h0200, 32'h11112222);
    addr(32'h0, 16'h0200); bus.rs2_val = 32'h33334444; bus.wr_en_mem = 1; #1;
    check("rw_old", bus.mem_out, 32'h11112222);
    @(posedge clk); #1;
    check("rw_new", bus.mem_out, 32'h33334444);

    store(32'hF0000000, 16'h0, 32'hABCD1234);
    check("hex0", {25'h0, HEX0}, 32'h19);
    check("hex3", {25'h0, HEX3}, 32'h79);
    addr(32'hF0000000, 16'h0); #1;
    check("load_hex", bus.mem_out, 32'h00001234);
    store(32'hF0000004, 16'h0, 32'hFFFFFFFF);
    check("ledr_store", {22'h0, LEDR}, 32'h3FF);

    addr(32'h0, 16'h0100); bus.rs2_val = 32'h0; bus.wr_en_mem = 1; #1;
    reset = 0; #1;
    check("mid_rst_ledr", {22'h0, LEDR}, 32'h0);
    check("mid_rst_ledg", {24'h0, LEDG}, 32'h0);
    check("mid_rst_hex0", {25'h0, HEX0}, 32'h40);
    check("mid_rst_hex3", {25'h0, HEX3}, 32'h40);
    @(posedge clk); #1;
    bus.wr_en_mem = 0; reset = 1; #1;
    check("ram_after_rst", bus.mem_out, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
